// File: rtl/insn_encoder_loader.sv
// insn_encoder_loader: encodes decoded RV32I instruction fields into 32-bit
// instruction words and streams them into instruction memory through a
// 2-entry FIFO, with an auto-incrementing word address and a saturating
// written-word counter.
//
// Optional feature: define INSN_ENCODER_RANGE_CHECK_EN to reject instructions
// whose immediate cannot be represented in the target format (sets errRange).
// Without it, immediates are truncated and errRange is tied to 0.

module insn_encoder_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int START_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  restart,
    input  logic                  inValid,
    output logic                  inReady,
    input  logic [6:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [31:0]           imm,
    output logic                  wrEnable,
    input  logic                  wrReady,
    output logic [ADDR_WIDTH-1:0] wrAddr,
    output logic [31:0]           wrData,
    output logic                  errIllegal,
    output logic                  errRange,
    output logic [ADDR_WIDTH:0]   wordCount
);

    // RV32I base opcodes
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [ADDR_WIDTH-1:0] START_W  = ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH:0]   WORD_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } fmt_e;

    fmt_e        fmt;
    logic [31:0] enc_word;
    logic        imm_ok;
    logic        shift_imm;
    logic        in_xfer;
    logic        out_xfer;
    logic        push;
    logic        pop;

    logic [1:0]  occupancy;
    logic [1:0]  occ_next;
    logic        in_ready_q;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [31:0] entry0;
    logic [31:0] entry1;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic        illegal_q;

    // Classify the incoming opcode into its instruction format
    always_comb begin
        fmt = FMT_NONE;
        case (opcode)
            OPC_OP:                                    fmt = FMT_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR,
            OPC_SYSTEM, OPC_MISC_MEM:                  fmt = FMT_I;
            OPC_STORE:                                 fmt = FMT_S;
            OPC_BRANCH:                                fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:                        fmt = FMT_U;
            OPC_JAL:                                   fmt = FMT_J;
            default:                                   fmt = FMT_NONE;
        endcase
    end

    assign shift_imm = (opcode == OPC_OP_IMM) && ((funct3 == 3'b001) || (funct3 == 3'b101));

    // Place the fields at their RV32I bit positions for the detected format
    always_comb begin
        enc_word = 32'h0;
        case (fmt)
            FMT_R: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: begin
                if (shift_imm) begin
                    enc_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                end else begin
                    enc_word = {imm[11:0], rs1, funct3, rd, opcode};
                end
            end
            FMT_S: enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U: enc_word = {imm[31:12], rd, opcode};
            FMT_J: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: enc_word = 32'h0;
        endcase
    end

`ifdef INSN_ENCODER_RANGE_CHECK_EN
    // Decide whether the immediate fits the encoding without loss
    always_comb begin
        imm_ok = 1'b1;
        case (fmt)
            FMT_I, FMT_S: imm_ok = (imm[31:11] == {21{imm[11]}});
            FMT_B:        imm_ok = !imm[0] && (imm[31:12] == {20{imm[12]}});
            FMT_J:        imm_ok = !imm[0] && (imm[31:20] == {12{imm[20]}});
            FMT_U:        imm_ok = (imm[11:0] == 12'h0);
            default:      imm_ok = 1'b1;
        endcase
    end
`else
    assign imm_ok = 1'b1;
`endif

    assign in_xfer  = inValid && inReady;
    assign out_xfer = wrEnable && wrReady;
    assign push     = in_xfer && (fmt != FMT_NONE) && imm_ok && !restart;
    assign pop      = out_xfer && !restart;

    // Next occupancy of the word buffer; restart empties it outright
    always_comb begin
        occ_next = occupancy;
        if (restart) begin
            occ_next = 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   occ_next = occupancy + 2'd1;
                2'b01:   occ_next = occupancy - 2'd1;
                default: occ_next = occupancy;
            endcase
        end
    end

    // Occupancy and a registered ready so inReady never sees wrReady combinationally
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            occupancy  <= 2'd0;
            in_ready_q <= 1'b0;
        end else begin
            occupancy  <= occ_next;
            in_ready_q <= (occ_next < 2'd2);
        end
    end

    // Read/write pointers of the 2-entry ring
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else if (restart) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    // Storage for the encoded words; entries are only written on a push
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            entry0 <= 32'h0;
            entry1 <= 32'h0;
        end else if (push) begin
            if (wr_ptr) begin
                entry1 <= enc_word;
            end else begin
                entry0 <= enc_word;
            end
        end
    end

    // Memory word address: advances once per accepted write, wraps naturally
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            addr_q <= START_W;
        end else if (restart) begin
            addr_q <= START_W;
        end else if (pop) begin
            addr_q <= addr_q + 1'b1;
        end
    end

    // Written-word counter that stops at the size of the address space
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count_q <= '0;
        end else if (restart) begin
            count_q <= '0;
        end else if (pop && (count_q != WORD_MAX)) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Sticky flag for accepted instructions with an unknown opcode
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            illegal_q <= 1'b0;
        end else if (restart) begin
            illegal_q <= 1'b0;
        end else if (in_xfer && (fmt == FMT_NONE)) begin
            illegal_q <= 1'b1;
        end
    end

`ifdef INSN_ENCODER_RANGE_CHECK_EN
    logic range_q;

    // Sticky flag for accepted instructions whose immediate does not fit
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            range_q <= 1'b0;
        end else if (restart) begin
            range_q <= 1'b0;
        end else if (in_xfer && (fmt != FMT_NONE) && !imm_ok) begin
            range_q <= 1'b1;
        end
    end

    assign errRange = range_q;
`else
    assign errRange = 1'b0;
`endif

    assign inReady    = in_ready_q;
    assign wrEnable   = (occupancy != 2'd0);
    assign wrData     = rd_ptr ? entry1 : entry0;
    assign wrAddr     = addr_q;
    assign wordCount  = count_q;
    assign errIllegal = illegal_q;

endmodule

// File: tb/tb_insn_encoder_loader.sv
// tb_insn_encoder_loader: vector table of known RV32I encodings, hand-written
// multi-cycle sequences and a randomized run, all compared against a
// queue-based reference model. Follows INSN_ENCODER_RANGE_CHECK_EN if defined.

module tb_insn_encoder_loader;

    localparam int AW    = 2;
    localparam int WORDS = 1 << AW;

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
    } insn_t;

    typedef struct {
        insn_t       insn;
        logic [31:0] word;
        bit          legal;
        string       name;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          restart;
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    opcode;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [31:0]   imm;
    logic          wr_enable;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          err_illegal;
    logic          err_range;
    logic [AW:0]   word_count;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [31:0] mq[$];
    int          m_addr;
    int          m_count;
    bit          m_ill;
    bit          m_rng;

    insn_encoder_loader #(
        .ADDR_WIDTH (AW),
        .START_ADDR (0)
    ) dut (
        .clk        (clk),
        .rstN       (rst_n),
        .restart    (restart),
        .inValid    (in_valid),
        .inReady    (in_ready),
        .opcode     (opcode),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .funct3     (funct3),
        .funct7     (funct7),
        .imm        (imm),
        .wrEnable   (wr_enable),
        .wrReady    (wr_ready),
        .wrAddr     (wr_addr),
        .wrData     (wr_data),
        .errIllegal (err_illegal),
        .errRange   (err_range),
        .wordCount  (word_count)
    );

    // free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic insn_t mk(input int op, input int d, input int s1, input int s2,
                                 input int f3, input int f7, input logic [31:0] im);
        insn_t t;
        t.op  = 7'(op);
        t.rd  = 5'(d);
        t.rs1 = 5'(s1);
        t.rs2 = 5'(s2);
        t.f3  = 3'(f3);
        t.f7  = 7'(f7);
        t.imm = im;
        return t;
    endfunction

    // 0 unknown, 1 R, 2 I, 3 S, 4 B, 5 U, 6 J
    function automatic int model_kind(input logic [6:0] op);
        case (op)
            7'h33:                             return 1;
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: return 2;
            7'h23:                             return 3;
            7'h63:                             return 4;
            7'h37, 7'h17:                      return 5;
            7'h6F:                             return 6;
            default:                           return 0;
        endcase
    endfunction

    function automatic bit model_in_range(input int kind, input logic [31:0] im);
        int s;
        s = int'(im);
        case (kind)
            2, 3:    return (s >= -2048) && (s <= 2047);
            4:       return (im[0] == 1'b0) && (s >= -4096) && (s <= 4094);
            5:       return (im % 4096) == 0;
            6:       return (im[0] == 1'b0) && (s >= -1048576) && (s <= 1048574);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_encode(input insn_t t);
        int unsigned op, d, s1, s2, f3, f7, im, w;
        op = t.op; d = t.rd; s1 = t.rs1; s2 = t.rs2; f3 = t.f3; f7 = t.f7; im = t.imm;
        w = 0;
        case (model_kind(t.op))
            1: w = (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7);
            2: begin
                if (op == 32'h13 && (f3 == 1 || f3 == 5))
                    w = (f7 << 25) | ((im % 32) << 20);
                else
                    w = (im % 4096) << 20;
                w = w | (s1 << 15) | (f3 << 12) | (d << 7);
            end
            3: w = (((im >> 5) % 128) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12)
                   | ((im % 32) << 7);
            4: w = (((im >> 12) & 1) << 31) | (((im >> 5) % 64) << 25) | (s2 << 20)
                   | (s1 << 15) | (f3 << 12) | (((im >> 1) % 16) << 8) | (((im >> 11) & 1) << 7);
            5: w = ((im / 4096) * 4096) | (d << 7);
            6: w = (((im >> 20) & 1) << 31) | (((im >> 1) % 1024) << 21)
                   | (((im >> 11) & 1) << 20) | (((im >> 12) % 256) << 12) | (d << 7);
            default: w = 0;
        endcase
        return w | op;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_addr  = 0;
        m_count = 0;
        m_ill   = 1'b0;
        m_rng   = 1'b0;
    endtask

    // one rising edge of the reference model, using pre-edge state
    task automatic model_clock(input bit v, input insn_t t, input bit wr_rdy, input bit rs);
        bit in_x;
        bit out_x;
        int k;
        if (rs) begin
            model_reset();
            return;
        end
        in_x  = v && (mq.size() < 2);
        out_x = (mq.size() > 0) && wr_rdy;
        if (out_x) begin
            void'(mq.pop_front());
            m_addr = (m_addr + 1) % WORDS;
            if (m_count < WORDS) m_count++;
        end
        if (in_x) begin
            k = model_kind(t.op);
            if (k == 0) begin
                m_ill = 1'b1;
            end else begin
`ifdef INSN_ENCODER_RANGE_CHECK_EN
                if (!model_in_range(k, t.imm)) m_rng = 1'b1;
                else mq.push_back(model_encode(t));
`else
                mq.push_back(model_encode(t));
`endif
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("inReady", 32'(in_ready), 32'(mq.size() < 2));
        checkOutput("wrEnable", 32'(wr_enable), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            checkOutput("wrData", wr_data, mq[0]);
            checkOutput("wrAddr", 32'(wr_addr), 32'(m_addr));
        end
        checkOutput("wordCount", 32'(word_count), 32'(m_count));
        checkOutput("errIllegal", 32'(err_illegal), 32'(m_ill));
        checkOutput("errRange", 32'(err_range), 32'(m_rng));
    endtask

    // drive one cycle of inputs (called at a falling edge), advance the model
    task automatic applyStimulus(input insn_t t, input bit v, input bit wr_rdy, input bit rs);
        in_valid = v;
        opcode   = t.op;
        rd       = t.rd;
        rs1      = t.rs1;
        rs2      = t.rs2;
        funct3   = t.f3;
        funct7   = t.f7;
        imm      = t.imm;
        wr_ready = wr_rdy;
        restart  = rs;
        @(posedge clk);
        model_clock(v, t, wr_rdy, rs);
        @(negedge clk);
        in_valid = 1'b0;
        restart  = 1'b0;
    endtask

    vec_t        vecs[16];
    insn_t       idle;
    insn_t       ins;
    logic [31:0] exp_addr[5];
    int          kind_ops[13];

    initial begin
        vecs[0]  = '{mk('h13, 1, 0, 0, 0, 0, 32'd5),          32'h00500093, 1'b1, "addi x1,x0,5"};
        vecs[1]  = '{mk('h23, 0, 1, 2, 2, 0, 32'd8),          32'h0020A423, 1'b1, "sw x2,8(x1)"};
        vecs[2]  = '{mk('h6F, 1, 0, 0, 0, 0, 32'd8),          32'h008000EF, 1'b1, "jal x1,8"};
        vecs[3]  = '{mk('h37, 5, 0, 0, 0, 0, 32'h12345000),   32'h123452B7, 1'b1, "lui x5"};
        vecs[4]  = '{mk('h33, 3, 1, 2, 0, 0, 32'd0),          32'h002081B3, 1'b1, "add x3,x1,x2"};
        vecs[5]  = '{mk('h33, 3, 1, 2, 0, 'h20, 32'd0),       32'h402081B3, 1'b1, "sub x3,x1,x2"};
        vecs[6]  = '{mk('h13, 5, 6, 0, 5, 'h20, 32'd3),       32'h40335293, 1'b1, "srai x5,x6,3"};
        vecs[7]  = '{mk('h13, 5, 6, 0, 5, 0, 32'h403),        32'h00335293, 1'b1, "srli funct7 wins"};
        vecs[8]  = '{mk('h63, 0, 1, 2, 0, 0, 32'd8),          32'h00208463, 1'b1, "beq x1,x2,8"};
        vecs[9]  = '{mk('h63, 0, 1, 2, 1, 0, 32'hFFFFFFFC),   32'hFE209EE3, 1'b1, "bne x1,x2,-4"};
        vecs[10] = '{mk('h67, 0, 1, 0, 0, 0, 32'd0),          32'h00008067, 1'b1, "jalr x0,0(x1)"};
        vecs[11] = '{mk('h17, 10, 0, 0, 0, 0, 32'h1000),      32'h00001517, 1'b1, "auipc x10"};
        vecs[12] = '{mk('h03, 7, 2, 0, 2, 0, 32'hFFFFFFFC),   32'hFFC12383, 1'b1, "lw x7,-4(x2)"};
        vecs[13] = '{mk('h6F, 0, 0, 0, 0, 0, 32'hFFFFFFF8),   32'hFF9FF06F, 1'b1, "jal x0,-8"};
        vecs[14] = '{mk('h0F, 0, 0, 0, 0, 0, 32'h0FF),        32'h0FF0000F, 1'b1, "fence"};
        vecs[15] = '{mk('h7F, 1, 2, 3, 0, 0, 32'd0),          32'h00000000, 1'b0, "opcode 0x7F"};

        kind_ops = '{'h33, 'h13, 'h03, 'h67, 'h73, 'h0F, 'h23, 'h63, 'h37, 'h17, 'h6F, 'h7F, 'h00};
        idle = mk(0, 0, 0, 0, 0, 0, 32'd0);

        rst_n    = 1'b0;
        restart  = 1'b0;
        in_valid = 1'b0;
        wr_ready = 1'b0;
        opcode   = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
        model_reset();

        // values held while reset is asserted
        repeat (2) @(negedge clk);
        checkOutput("reset inReady", 32'(in_ready), 32'd0);
        checkOutput("reset wrEnable", 32'(wr_enable), 32'd0);
        checkOutput("reset wrAddr", 32'(wr_addr), 32'd0);
        checkOutput("reset wrData", wr_data, 32'd0);
        checkOutput("reset wordCount", 32'(word_count), 32'd0);
        checkOutput("reset errIllegal", 32'(err_illegal), 32'd0);
        checkOutput("reset errRange", 32'(err_range), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkAll();

        // table of known encodings, one instruction at a time
        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].insn, 1'b1, 1'b1, 1'b0);
            checkAll();
            if (vecs[i].legal) begin
                checkOutput({"enc ", vecs[i].name}, wr_data, vecs[i].word);
                checkOutput({"model ", vecs[i].name}, model_encode(vecs[i].insn), vecs[i].word);
            end else begin
                checkOutput({"nowrite ", vecs[i].name}, 32'(wr_enable), 32'd0);
                checkOutput({"errIllegal ", vecs[i].name}, 32'(err_illegal), 32'd1);
            end
            applyStimulus(idle, 1'b0, 1'b1, 1'b0);
            checkAll();
        end

        // restart clears the error and reloads the address
        applyStimulus(idle, 1'b0, 1'b1, 1'b1);
        checkAll();
        checkOutput("restart errIllegal", 32'(err_illegal), 32'd0);
        applyStimulus(vecs[0].insn, 1'b1, 1'b1, 1'b0);
        checkAll();
        checkOutput("restart first wrAddr", 32'(wr_addr), 32'd0);
        applyStimulus(idle, 1'b0, 1'b1, 1'b0);

        // back-to-back sw, jal, lui
        applyStimulus(idle, 1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(vecs[i].insn, 1'b1, 1'b1, 1'b0);
            checkAll();
            checkOutput("b2b wrData", wr_data, vecs[i].word);
            checkOutput("b2b wrAddr", 32'(wr_addr), 32'(i - 1));
        end
        applyStimulus(idle, 1'b0, 1'b1, 1'b0);
        checkAll();
        checkOutput("b2b wordCount", 32'(word_count), 32'd3);

        // backpressure: two of three offers accepted, head word held
        applyStimulus(idle, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(mk('h13, i, 0, 0, 0, 0, 32'(i)), 1'b1, 1'b0, 1'b0);
            checkAll();
            checkOutput("bp held wrData", wr_data, 32'h00100093);
        end
        checkOutput("bp inReady", 32'(in_ready), 32'd0);
        applyStimulus(idle, 1'b0, 1'b1, 1'b0);
        checkAll();
        checkOutput("bp second word", wr_data, 32'h00200113);
        checkOutput("bp inReady back", 32'(in_ready), 32'd1);
        applyStimulus(idle, 1'b0, 1'b1, 1'b0);
        checkAll();
        checkOutput("bp drained", 32'(wr_enable), 32'd0);

        // restart beats a same-cycle input and output transfer
        applyStimulus(vecs[0].insn, 1'b1, 1'b0, 1'b0);
        applyStimulus(vecs[4].insn, 1'b1, 1'b1, 1'b1);
        checkAll();
        checkOutput("restart wins wrEnable", 32'(wr_enable), 32'd0);
        checkOutput("restart wins wordCount", 32'(word_count), 32'd0);

        // address wrap and count saturation over five writes
        exp_addr = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[0].insn, 1'b1, 1'b1, 1'b0);
            checkAll();
            checkOutput("wrap wrAddr", 32'(wr_addr), exp_addr[i]);
        end
        applyStimulus(idle, 1'b0, 1'b1, 1'b0);
        checkAll();
        checkOutput("saturated wordCount", 32'(word_count), 32'd4);

        // misaligned branch offset
        applyStimulus(idle, 1'b0, 1'b1, 1'b1);
        applyStimulus(mk('h63, 0, 1, 2, 0, 0, 32'd3), 1'b1, 1'b1, 1'b0);
        checkAll();
`ifdef INSN_ENCODER_RANGE_CHECK_EN
        checkOutput("odd branch nowrite", 32'(wr_enable), 32'd0);
        checkOutput("odd branch errRange", 32'(err_range), 32'd1);
`else
        checkOutput("odd branch written", 32'(wr_enable), 32'd1);
        checkOutput("odd branch errRange", 32'(err_range), 32'd0);
`endif
        applyStimulus(idle, 1'b0, 1'b1, 1'b0);

        // reset in the middle of buffered traffic discards everything
        applyStimulus(idle, 1'b0, 1'b0, 1'b1);
        applyStimulus(vecs[0].insn, 1'b1, 1'b0, 1'b0);
        applyStimulus(vecs[4].insn, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset wrEnable", 32'(wr_enable), 32'd0);
        checkOutput("async reset inReady", 32'(in_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkAll();
        applyStimulus(idle, 1'b0, 1'b1, 1'b0);
        checkAll();
        checkOutput("post reset no write", 32'(word_count), 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            ins.op  = 7'(kind_ops[$urandom_range(0, 12)]);
            ins.rd  = 5'($urandom);
            ins.rs1 = 5'($urandom);
            ins.rs2 = 5'($urandom);
            ins.f3  = 3'($urandom);
            ins.f7  = 7'($urandom);
            case ($urandom_range(0, 3))
                0:       ins.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
                1:       ins.imm = $urandom;
                2:       ins.imm = $urandom & 32'hFFFFF000;
                default: ins.imm = 32'(int'($urandom_range(0, 8191)) - 4096) & 32'hFFFFFFFE;
            endcase
            applyStimulus(ins, ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 63) == 0));
            checkAll();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/insn_encoder_loader.md
INSN_ENCODER_LOADER -- requirements
Module: insn_encoder_loader

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, instruction-memory word-address width.
REQ-002 SHALL have parameter START_ADDR, default 0, word address loaded into the address counter at reset and on restart.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rstN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port restart  input  1  synchronous pulse: empty the buffer, reload the address counter, clear the error flags.
REQ-006 SHALL have port inValid / inReady  input / output  1 / 1  decoded-instruction handshake.
REQ-007 SHALL have ports opcode 7, rd 5, rs1 5, rs2 5, funct3 3, funct7 7, imm 32, all inputs carrying the decoded instruction fields.
REQ-008 SHALL have port wrEnable / wrReady  output / input  1 / 1  instruction-memory write handshake.
REQ-009 SHALL have port wrAddr  output  ADDR_WIDTH  word address of the current write.
REQ-010 SHALL have port wrData  output  32  encoded RV32I instruction word.
REQ-011 SHALL have ports errIllegal, errRange  output  1 each  sticky error flags.
REQ-012 SHALL have port wordCount  output  ADDR_WIDTH+1  number of words written since reset or restart, saturating.

Function
REQ-013 Transfer rules:
- Input transfer when inValid && inReady.
- Output transfer when wrEnable && wrReady.
REQ-014 inReady SHALL be 1 exactly when the registered buffer occupancy is below 2, and SHALL NOT depend combinationally on wrReady.
REQ-015 Encoding SHALL happen on input transfer; the encoded word SHALL enter a 2-entry FIFO. With the FIFO empty, wrEnable SHALL assert the following cycle (latency 1).
REQ-016 Encoding by opcode:
- R-type: OP.
- I-type: OP_IMM, LOAD, JALR, SYSTEM, MISC_MEM.
- S-type: STORE.
- B-type: BRANCH.
- U-type: LUI, AUIPC.
- J-type: JAL.
- Fields are placed at the standard RV32I bit positions; the opcode occupies bits 6:0.
REQ-017 For OP_IMM with funct3 001 or 101, bits 31:25 SHALL be funct7 and bits 24:20 SHALL be imm[4:0].
REQ-018 U-type SHALL take imm[31:12]; B-type and J-type SHALL take imm bits 12:1 and 20:1 respectively in scrambled order; S-type and I-type SHALL take imm[11:0].
REQ-019 An opcode outside REQ-016 SHALL be accepted (inReady honoured), not written, and SHALL set errIllegal.
REQ-020 wrEnable SHALL equal FIFO-not-empty. wrAddr and wrData SHALL stay stable while wrEnable && !wrReady.
REQ-021 The address counter SHALL increment by 1 per output transfer and wrap modulo 2^ADDR_WIDTH.
REQ-022 wordCount SHALL increment per output transfer and saturate at 2^ADDR_WIDTH.
REQ-023 Simultaneous input and output transfer SHALL keep occupancy unchanged and preserve FIFO order.
REQ-024 On restart, restart SHALL win over same-cycle transfers:
- The input is not captured and no write counts.
- Occupancy becomes 0 and the address reloads to START_ADDR.
- errIllegal, errRange and wordCount clear.
- inReady is 1 the next cycle.

Reset
REQ-025 On rstN low, asynchronously:
- Occupancy 0; wrEnable 0; inReady 0 while rstN is low, then 1 in the first cycle after release.
- wrAddr = START_ADDR; wrData = 0.
- errIllegal 0, errRange 0, wordCount 0.
REQ-026 Reset asserted mid-transfer SHALL discard all buffered words without a write.

Configuration
REQ-027 With INSN_ENCODER_RANGE_CHECK_EN defined, an instruction with an unrepresentable immediate SHALL be accepted, not written, and SHALL set errRange. Unrepresentable means:
- I/S: imm is not a sign-extended 12-bit value.
- B: imm is odd or outside -4096..4094.
- J: imm is odd or outside +/-1 MiB.
- U: imm[11:0] is not 0.
REQ-028 Without INSN_ENCODER_RANGE_CHECK_EN, immediates SHALL be truncated silently and errRange SHALL be tied to 0.

Verification
REQ-029 addi x1,x0,5 (OP_IMM, rd=1, imm=5), wrReady=1 -> next cycle wrEnable=1, wrAddr=0, wrData=0x00500093.
REQ-030 sw x2,8(x1), then jal x1,8, then lui x5 with imm=0x12345000, back-to-back -> wrData sequence 0x0020A423, 0x008000EF, 0x123452B7 at wrAddr 0,1,2; wordCount=3.
REQ-031 wrReady=0, three valid inputs offered -> two accepted, inReady=0, wrData held; wrReady=1 -> both words written in order, inReady returns to 1.
REQ-032 opcode 0x7F -> no write, errIllegal=1; restart pulse -> errIllegal=0, next write at START_ADDR.
REQ-033 ADDR_WIDTH=2, 5 writes -> wrAddr sequence 0,1,2,3,0; wordCount saturates at 4.
REQ-034 With the macro defined, BRANCH imm=3 -> no write, errRange=1; without the macro, the same stimulus is written with errRange=0.
